// File: rtl/ap_mon_pkg.sv
// Shared definitions for the ap_ctrl_chain statistics monitor:
// statistic select encoding and the FLAGS word layout.
package ap_mon_pkg;

    typedef enum logic [2:0] {
        START_CNT = 3'd0,
        DONE_CNT  = 3'd1,
        BUSY_CYC  = 3'd2,
        STALL_CYC = 3'd3,
        LAST_LAT  = 3'd4,
        MAX_LAT   = 3'd5,
        MIN_LAT   = 3'd6,
        FLAGS     = 3'd7
    } stat_sel_e;

    localparam int NUM_STAT = 8;

    // FLAGS word: {zero-pad, occupancy, ovf, unf}
    localparam int FLG_UNF     = 0;
    localparam int FLG_OVF     = 1;
    localparam int FLG_OCC_LSB = 2;

endpackage

// File: rtl/ap_ch_tracker.sv
// One monitored kernel: timestamp FIFO for in-flight transactions,
// event decode, saturating counters, latency stats and sticky flags.
module ap_ch_tracker
    import ap_mon_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [TS_W-1:0]                    ts,
    input  logic                               ap_start,
    input  logic                               ap_ready,
    input  logic                               ap_done,
    input  logic                               ap_continue,
    input  logic                               clear,
    input  logic                               finish,
    output logic [NUM_STAT-1:0][CNT_W-1:0]     stat,
    output logic                               err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] start_cnt, done_cnt, busy_cyc, stall_cyc;
    logic [TS_W-1:0]  last_lat, max_lat, min_lat;
    logic             ovf, unf;

    logic             start_ev, done_ev, stall_ev, busy_ev;
    logic             empty, full;
    logic             push, pop, lat_vld, set_ovf, set_unf;
    logic [TS_W-1:0]  lat_val;
    logic             upd;
    logic [CNT_W-1:0] flags_w;

    assign start_ev = ap_start & ap_ready;
    assign done_ev  = ap_done & ap_continue;
    assign stall_ev = ap_done & ~ap_continue;
    assign empty    = (occ == '0);
    assign full     = (occ == OCC_W'(DEPTH));
    assign busy_ev  = ~empty | start_ev;
    assign upd      = ~clear & ~finish;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Event resolution; a simultaneous pop frees the slot the push needs,
    // so a full FIFO with start+done neither overflows nor changes occupancy.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        lat_vld = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        lat_val = ts - mem[rd_ptr];
        if (done_ev) begin
            if (empty) begin
                if (start_ev) begin
                    lat_vld = 1'b1;
                    lat_val = '0;
                end else begin
                    set_unf = 1'b1;
                end
            end else begin
                pop     = 1'b1;
                lat_vld = 1'b1;
                push    = start_ev;
            end
        end else if (start_ev) begin
            if (full) set_ovf = 1'b1;
            else      push    = 1'b1;
        end
    end

    // Timestamp storage; needs no reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (push && upd) mem[wr_ptr] <= ts;
    end

    // Pointers, counters, latency stats and sticky flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            start_cnt <= '0;
            done_cnt  <= '0;
            busy_cyc  <= '0;
            stall_cyc <= '0;
            last_lat  <= '0;
            max_lat   <= '0;
            min_lat   <= '1;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            start_cnt <= '0;
            done_cnt  <= '0;
            busy_cyc  <= '0;
            stall_cyc <= '0;
            last_lat  <= '0;
            max_lat   <= '0;
            min_lat   <= '1;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (!finish) begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
            start_cnt <= sat_inc(start_cnt, start_ev);
            done_cnt  <= sat_inc(done_cnt, done_ev);
            busy_cyc  <= sat_inc(busy_cyc, busy_ev);
            stall_cyc <= sat_inc(stall_cyc, stall_ev);
            if (lat_vld) begin
                last_lat <= lat_val;
                if (lat_val > max_lat) max_lat <= lat_val;
                if (lat_val < min_lat) min_lat <= lat_val;
            end
            if (set_ovf) ovf <= 1'b1;
            if (set_unf) unf <= 1'b1;
        end
    end

    // FLAGS word assembly.
    always_comb begin
        flags_w                        = '0;
        flags_w[FLG_UNF]               = unf;
        flags_w[FLG_OVF]               = ovf;
        flags_w[FLG_OCC_LSB +: OCC_W]  = occ;
    end

    assign stat[START_CNT] = start_cnt;
    assign stat[DONE_CNT]  = done_cnt;
    assign stat[BUSY_CYC]  = busy_cyc;
    assign stat[STALL_CYC] = stall_cyc;
    assign stat[LAST_LAT]  = CNT_W'(last_lat);
    assign stat[MAX_LAT]   = CNT_W'(max_lat);
    assign stat[MIN_LAT]   = CNT_W'(min_lat);
    assign stat[FLAGS]     = flags_w;
    assign err             = ovf | unf;

endmodule

// File: rtl/ap_ctrl_stat_monitor.sv
// ap_ctrl_chain statistics monitor: shared timestamp, one tracker per
// channel, registered channel/statistic readout and error summary.
module ap_ctrl_stat_monitor
    import ap_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int CNT_W  = 32,
    localparam int RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              clear,
    input  logic              finish,
    input  logic [RD_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              any_err
);

    logic [TS_W-1:0]                           ts;
    logic [NUM_CH-1:0][NUM_STAT-1:0][CNT_W-1:0] stat_all;
    logic [NUM_CH-1:0]                         err_vec;
    logic [CNT_W-1:0]                          rd_mux;

    // Free-running timestamp; unaffected by clear and finish.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ap_ch_tracker #(
            .DEPTH (DEPTH),
            .TS_W  (TS_W),
            .CNT_W (CNT_W)
        ) u_trk (
            .clock       (clock),
            .reset       (reset),
            .ts          (ts),
            .ap_start    (ap_start[c]),
            .ap_ready    (ap_ready[c]),
            .ap_done     (ap_done[c]),
            .ap_continue (ap_continue[c]),
            .clear       (clear),
            .finish      (finish),
            .stat        (stat_all[c]),
            .err         (err_vec[c])
        );
    end

    // Readout select; channel numbers beyond NUM_CH read as zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(rd_ch) == c) rd_mux = stat_all[c][rd_sel];
        end
    end

    // Registered readout and error summary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            any_err <= 1'b0;
        end else begin
            rd_data <= rd_mux;
            any_err <= |err_vec;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_stat_monitor.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a queue-based transaction model of every channel.
module tb_ap_ctrl_stat_monitor;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int CNT_W  = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
    logic              clear, finish;
    logic [1:0]        rd_ch;
    logic [2:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              any_err;

    int n_chk  = 0;
    int n_fail = 0;

    ap_ctrl_stat_monitor #(
        .NUM_CH (NUM_CH), .DEPTH (DEPTH), .TS_W (TS_W), .CNT_W (CNT_W)
    ) dut (
        .clock (clock), .reset (reset),
        .ap_start (ap_start), .ap_ready (ap_ready),
        .ap_done (ap_done), .ap_continue (ap_continue),
        .clear (clear), .finish (finish),
        .rd_ch (rd_ch), .rd_sel (rd_sel),
        .rd_data (rd_data), .any_err (any_err)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [31:0] m_start [NUM_CH];
    logic [31:0] m_done  [NUM_CH];
    logic [31:0] m_busy  [NUM_CH];
    logic [31:0] m_stall [NUM_CH];
    logic [15:0] m_last  [NUM_CH];
    logic [15:0] m_max   [NUM_CH];
    logic [15:0] m_min   [NUM_CH];
    bit          m_ovf   [NUM_CH];
    bit          m_unf   [NUM_CH];
    logic [15:0] m_q     [NUM_CH][$];
    logic [15:0] m_ts;

    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_start[c] = 0; m_done[c] = 0; m_busy[c] = 0; m_stall[c] = 0;
            m_last[c] = 0; m_max[c] = 0; m_min[c] = 16'hFFFF;
            m_ovf[c] = 0; m_unf[c] = 0;
            m_q[c].delete();
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_ts = 0;
    endtask

    task automatic rec_lat(input int c, input logic [15:0] l);
        m_last[c] = l;
        if (l > m_max[c]) m_max[c] = l;
        if (l < m_min[c]) m_min[c] = l;
    endtask

    // Applies one clock edge worth of transactions to the model.
    task automatic model_update();
        bit s, d;
        if (!reset) return;
        if (clear) model_clear();
        else if (!finish) begin
            for (int c = 0; c < NUM_CH; c++) begin
                s = ap_start[c] & ap_ready[c];
                d = ap_done[c] & ap_continue[c];
                if (s) m_start[c] = sinc(m_start[c]);
                if (d) m_done[c] = sinc(m_done[c]);
                if (m_q[c].size() > 0 || s) m_busy[c] = sinc(m_busy[c]);
                if (ap_done[c] & ~ap_continue[c]) m_stall[c] = sinc(m_stall[c]);
                if (d && m_q[c].size() == 0 && s) begin
                    rec_lat(c, 16'd0);
                end else begin
                    if (d) begin
                        if (m_q[c].size() == 0) m_unf[c] = 1;
                        else rec_lat(c, m_ts - m_q[c].pop_front());
                    end
                    if (s) begin
                        if (m_q[c].size() >= DEPTH) m_ovf[c] = 1;
                        else m_q[c].push_back(m_ts);
                    end
                end
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    function automatic logic [31:0] exp_stat(input int c, input int sel);
        case (sel)
            0: return m_start[c];
            1: return m_done[c];
            2: return m_busy[c];
            3: return m_stall[c];
            4: return {16'd0, m_last[c]};
            5: return {16'd0, m_max[c]};
            6: return {16'd0, m_min[c]};
            default: return (32'(m_q[c].size()) << 2) | (32'(m_ovf[c]) << 1) | 32'(m_unf[c]);
        endcase
    endfunction

    function automatic bit exp_err();
        bit e = 0;
        for (int c = 0; c < NUM_CH; c++) e |= m_ovf[c] | m_unf[c];
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle();
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        clear = 0; finish = 0;
    endtask

    // Freezes statistics, reads one value and compares with a constant.
    task automatic rd_chk(input string tag, input int c, input int sel, input logic [31:0] exp_v);
        idle();
        finish = 1;
        rd_ch = 2'(c); rd_sel = 3'(sel);
        tick();
        chk(tag, rd_data, exp_v);
        finish = 0;
    endtask

    // Freezes statistics and compares every readout against the model.
    task automatic snapshot(input string tag);
        idle();
        finish = 1;
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < 8; s++) begin
                rd_ch = 2'(c); rd_sel = 3'(s);
                tick();
                chk($sformatf("%s ch%0d sel%0d", tag, c, s), rd_data, exp_stat(c, s));
            end
        chk({tag, " any_err"}, 32'(any_err), 32'(exp_err()));
        finish = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_ch = 0; rd_sel = 0;
        idle();
        reset = 0;
        model_reset();
        repeat (3) tick();
        reset = 1;
        snapshot("reset");

        // Sequential transactions, latency 15 each.
        for (int r = 0; r < 3; r++) begin
            idle(); ap_start[0] = 1; ap_ready[0] = 1; tick();
            idle(); repeat (14) tick();
            ap_done[0] = 1; tick();
            idle(); repeat (3) tick();
        end
        rd_chk("seq start", 0, 0, 3);
        rd_chk("seq done", 0, 1, 3);
        rd_chk("seq busy", 0, 2, 48);
        rd_chk("seq last", 0, 4, 15);
        rd_chk("seq max", 0, 5, 15);
        rd_chk("seq min", 0, 6, 15);

        // Pipelined: 8 starts, dones 20 cycles after each start.
        idle(); ap_start[1] = 1; ap_ready[1] = 1;
        repeat (8) tick();
        idle(); rd_ch = 1; rd_sel = 3'd7;
        repeat (2) tick();
        chk("pipe peak occ", rd_data, 32'd32);
        repeat (10) tick();
        ap_done[1] = 1;
        repeat (8) tick();
        idle();
        rd_chk("pipe last", 1, 4, 20);
        rd_chk("pipe max", 1, 5, 20);
        rd_chk("pipe min", 1, 6, 20);
        rd_chk("pipe flags", 1, 7, 0);

        // Overflow: 9 starts into a depth-8 tracker.
        idle(); ap_start[2] = 1; ap_ready[2] = 1;
        repeat (9) tick();
        idle();
        chk("ovf err lag", 32'(any_err), 0);
        tick();
        chk("ovf err set", 32'(any_err), 1);
        rd_chk("ovf start", 2, 0, 9);
        rd_chk("ovf flags", 2, 7, 32'h22);

        // Same-cycle start/done on empty, then done without start.
        idle(); ap_start[3] = 1; ap_ready[3] = 1; ap_done[3] = 1; tick();
        idle();
        rd_chk("same last", 3, 4, 0);
        rd_chk("same min", 3, 6, 0);
        rd_chk("same flags", 3, 7, 0);
        ap_done[3] = 1; tick(); idle();
        rd_chk("unf flags", 3, 7, 1);

        // Stall, then events while frozen.
        idle(); ap_done[0] = 1; ap_continue[0] = 0;
        repeat (5) tick();
        idle();
        rd_chk("stall cnt", 0, 3, 5);
        for (int i = 0; i < 10; i++) begin
            ap_start = 4'($urandom); ap_ready = 4'($urandom);
            ap_done = 4'($urandom); ap_continue = 4'($urandom);
            finish = 1;
            tick();
        end
        snapshot("frozen");

        // Clear wins over a same-cycle start.
        idle(); clear = 1; ap_start[0] = 1; ap_ready[0] = 1; tick();
        idle();
        rd_chk("clear start", 0, 0, 0);
        snapshot("clear");

        // Random traffic.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 100; i++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    ap_start[c]    = ($urandom_range(0, 2) == 0);
                    ap_ready[c]    = ($urandom_range(0, 3) != 0);
                    ap_done[c]     = (m_q[c].size() > 0) ? ($urandom_range(0, 2) == 0)
                                                         : ($urandom_range(0, 30) == 0);
                    ap_continue[c] = ($urandom_range(0, 4) != 0);
                end
                clear  = ($urandom_range(0, 99) == 0);
                finish = ($urandom_range(0, 19) == 0);
                tick();
            end
            snapshot($sformatf("rand%0d", r));
        end

        // Async reset with transactions in flight.
        idle(); clear = 1; tick();
        idle(); ap_start = '1; ap_ready = '1;
        repeat (3) tick();
        #2 reset = 0;
        model_reset();
        idle();
        tick();
        reset = 1;
        snapshot("post-reset");
        rd_chk("reset min", 0, 6, 32'hFFFF);
        ap_done[0] = 1; tick(); idle();
        rd_chk("reset unf", 0, 7, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_stat_monitor.md
# ap_ctrl_stat_monitor

Synthesizable, parametrised monitor for the `ap_ctrl_chain` handshake of up to `NUM_CH` HLS kernels, such as `apskmod` and its siblings in the modem datapath. It observes each channel's start, ready, done and continue signals without driving them. Per channel it counts transactions, busy cycles and back-pressure stalls, and it measures per-transaction latency for pipelined kernels with several transactions in flight. Statistics are read through a registered select/readout port, so the same block serves the simulation bench and on-board debug over the XDMA register space.

## Interface
- `NUM_CH`, 4: number of monitored kernels, 1..16.
- `DEPTH`, 8: in-flight transactions tracked per channel; power of two, 2..64.
- `TS_W`, 16: width of the free-running timestamp and of the latency values.
- `CNT_W`, 32: width of the counters and of `rd_data`; must be at least `TS_W` and at least `$clog2(DEPTH+1)+2`.

Ports (name, direction, width, meaning):
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ap_start`  in  `NUM_CH`  per-channel kernel start.
- `ap_ready`  in  `NUM_CH`  per-channel input accepted.
- `ap_done`  in  `NUM_CH`  per-channel output valid.
- `ap_continue`  in  `NUM_CH`  per-channel downstream accept; tie to 1 when the kernel has no continue.
- `clear`  in  1  synchronous clear of all statistics and trackers.
- `finish`  in  1  level; freezes all statistics while high.
- `rd_ch`  in  `$clog2(NUM_CH)` (minimum 1)  channel to read.
- `rd_sel`  in  3  statistic select, `stat_sel_e`.
- `rd_data`  out  `CNT_W`  registered readout.
- `any_err`  out  1  OR of all channels' overflow and underflow flags.

## Operation
- Events per channel:
  - `start_ev = ap_start & ap_ready`.
  - `done_ev = ap_done & ap_continue`.
  - `stall = ap_done & ~ap_continue`.
- Timestamp: `ts` is a `TS_W`-bit free-running counter that wraps modulo 2^TS_W and keeps running while `finish` is high.
- Tracker: a per-channel FIFO of `DEPTH` timestamps.
  - `start_ev` pushes `ts`.
  - `done_ev` pops the oldest entry and computes `lat = ts - popped`, modulo 2^TS_W.
- Boundary cases:
  - `start_ev` and `done_ev` in the same cycle, FIFO empty: `lat = 0`, nothing pushed, no underflow.
  - Same, FIFO non-empty: pop and push both happen and occupancy is unchanged. This holds even when the FIFO is full, and no overflow is flagged.
  - `start_ev` alone with the FIFO full: the push is dropped, `ovf` is set (sticky) and `START_CNT` still increments.
  - `done_ev` alone with the FIFO empty: `unf` is set (sticky), no latency update, `DONE_CNT` still increments.
- Statistics selected by `stat_sel_e`:
  - 0 `START_CNT`, 1 `DONE_CNT`.
  - 2 `BUSY_CYC`: cycles with occupancy > 0 or `start_ev`.
  - 3 `STALL_CYC`.
  - 4 `LAST_LAT`, 5 `MAX_LAT`, 6 `MIN_LAT`.
  - 7 `FLAGS`: `{zero-pad, occupancy, ovf, unf}`.
- Counting rules:
  - Counters saturate at all-ones and never wrap.
  - Latency values are zero-extended to `CNT_W`.
  - `MIN_LAT` resets to all-ones in `TS_W`, so it reads 2^TS_W-1 until the first latency is recorded.
- `finish` high: no statistic, flag or tracker updates; `rd_data` remains readable.
- `clear`: zeroes all statistics, empties the trackers, clears flags and sets `MIN_LAT` to all-ones. It wins over same-cycle events, which are discarded. `ts` is not cleared.

## Timing
- Reset (`reset` low) sets:
  - every counter, flag, FIFO pointer and `ts` to 0;
  - `MIN_LAT` to all-ones;
  - `rd_data` to 0 and `any_err` to 0.
- Event cycle N updates the statistics at the edge ending cycle N; they are visible internally in cycle N+1.
- `rd_data` is registered: `rd_ch`/`rd_sel` sampled at edge E appear after E, so the readout lags by one cycle.
- A statistic updated at edge E and read with the address presented in the same cycle shows the new value after edge E+1.
- `any_err` is registered and asserts one cycle after the flag sets.
- Latency convention: a transaction started in cycle S and done in cycle D reports `D-S`; back-to-back cycles report 1.
- Reset asserted mid-transaction drops all in-flight entries with no error. A `done_ev` after reset for a pre-reset start sets `unf`.

## Structure
- Package `ap_mon_pkg`: `stat_sel_e` enum (3 bits) and the `FLAGS` field layout constants.
- Sub-module `ap_ch_tracker`, instantiated `NUM_CH` times via generate. It holds the timestamp FIFO, the event logic, the counters and the flags.
- Top level: `ts` counter, readout mux and register, `any_err` reduction.

## Test plan
- Single channel, sequential use: start at cycle 10, done at cycle 25, repeated 3 times. Expect `START_CNT=3`, `DONE_CNT=3`, `LAST_LAT=MAX_LAT=MIN_LAT=15`, `BUSY_CYC=48`.
- Pipelined use, `DEPTH=8`: 8 starts on consecutive cycles, then 8 dones on consecutive cycles 20 later. Expect every latency 20, occupancy peak 8, no flags set.
- Overflow: 9 starts with no done. Expect `ovf=1`, `START_CNT=9`, occupancy 8 and `any_err=1` one cycle later.
- Same-cycle start and done on an empty FIFO: `LAST_LAT=0`, `MIN_LAT=0`, no `unf`. A done with no prior start sets `unf`.
- Stall and freeze: `ap_done` high with `ap_continue` low for 5 cycles gives `STALL_CYC=5`. With `finish` high, further events leave all statistics unchanged.
- Clear and reset:
  - `clear` in the same cycle as `start_ev`: `START_CNT=0`.
  - Async reset mid-flight: all reads return 0 except `MIN_LAT`, which returns 0xFFFF with `TS_W=16`.
